btod_req_issuer: RTL and testbench

- Upstream neighbour of blockB. It owns the initiator side of the btod request/ack channel and the startDone notify/ack channel that blockB receives.
- After reset it sends one startDone notification and waits for blockB to acknowledge it.
- It then drains a 4-deep command FIFO, filled by a rdy/vld producer, onto btod, one outstanding request at a time.
- Each ack payload is returned to the producer side through a 1-entry response register.
- It monitors ack latency, raises a sticky timeout flag and keeps request/ack statistics.

---
 rtl/btod_req_issuer_pkg.sv | 20 ++
 rtl/btod_req_issuer_sync_fifo.sv | 53 +++++
 rtl/btod_req_issuer.sv | 164 ++++++++++++++++
 tb/tb_btod_req_issuer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btod_req_issuer_pkg.sv
// Shared types and default sizes for the btod request issuer and its command FIFO.
package btod_issuer_package;

  localparam int REQ_W_DEF       = 32;
  localparam int ACK_W_DEF       = 32;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    S_START    = 2'd0,
    S_NOTIFY   = 2'd1,
    S_READY    = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_e;

  typedef logic [REQ_W_DEF-1:0] cmdSt;
  typedef logic [ACK_W_DEF-1:0] ackSt;

endpackage

// File: rtl/btod_req_issuer_sync_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate count.
module sync_fifo #(
  parameter int  DEPTH  = 4,
  parameter type data_t = btod_issuer_package::cmdSt
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  data_t i_push_data,
  input  logic  i_pop,
  output data_t o_head,
  output logic  o_full,
  output logic  o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  data_t       r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Over-push and under-pop are dropped here so the caller cannot corrupt pointers.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/btod_req_issuer.sv
// Initiator for the btod request/ack channel: startDone handshake, then drains the
// command FIFO one outstanding request at a time, returning ack payloads via a 1-entry register.
//
// state      | meaning
// S_START    | first cycle after reset release, everything idle
// S_NOTIFY   | start_notify held high until start_ack
// S_READY    | started; issue when a command and a free rsp slot exist
// S_WAIT_ACK | btod_req held with stable data until btod_ack
module btod_req_issuer
  import btod_issuer_package::*;
#(
  parameter int REQ_W       = REQ_W_DEF,
  parameter int ACK_W       = ACK_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [REQ_W-1:0] cmd_data,
  output logic             btod_req,
  output logic [REQ_W-1:0] btod_req_data,
  input  logic             btod_ack,
  input  logic [ACK_W-1:0] btod_ack_data,
  output logic             start_notify,
  input  logic             start_ack,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [ACK_W-1:0] rsp_data,
  output logic             started,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] ack_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WCNT_W-1:0] WCNT_SET = WCNT_W'(TIMEOUT_CYC - 2);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [REQ_W-1:0]  r_req_data;
  logic              r_rsp_vld;
  logic [ACK_W-1:0]  r_rsp_data;
  logic              r_started;
  logic              r_err_timeout;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [CNT_W-1:0]  r_ack_cnt;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [REQ_W-1:0]  w_fifo_head;
  logic              w_push;
  logic              w_issue;
  logic              w_ack_take;
  logic              w_rsp_drain;
  logic              w_to_set;
  logic              w_in_wait;

  assign w_in_wait   = (r_state == S_WAIT_ACK);
  assign w_rsp_drain = r_rsp_vld & rsp_rdy;
  assign w_push      = cmd_vld & cmd_rdy;
  // Issue only when the response slot is free by the time this ack could land.
  assign w_issue     = (r_state == S_READY) & ~w_fifo_empty & (~r_rsp_vld | rsp_rdy);
  assign w_ack_take  = w_in_wait & btod_ack;
  assign w_to_set    = w_in_wait & ~btod_ack & (r_wait_cnt == WCNT_SET);

  sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (logic [REQ_W-1:0])
  ) u_cmd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (cmd_data),
    .i_pop       (w_issue),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_START;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_START:    w_state_nxt = S_NOTIFY;
      S_NOTIFY:   if (start_ack) w_state_nxt = S_READY;
      S_READY:    if (w_issue) w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (btod_ack) w_state_nxt = S_READY;
      default:    w_state_nxt = S_START;
    endcase
  end

  always_comb begin
    start_notify = (r_state == S_NOTIFY);
    btod_req     = (r_state == S_WAIT_ACK);
    cmd_rdy      = (r_state != S_START) & ~w_fifo_full;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_data    <= '0;
      r_rsp_vld     <= 1'b0;
      r_rsp_data    <= '0;
      r_started     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wait_cnt    <= '0;
      r_req_cnt     <= '0;
      r_ack_cnt     <= '0;
    end else begin
      if (start_notify && start_ack) begin
        r_started <= 1'b1;
      end

      if (w_issue) begin
        r_req_data <= w_fifo_head;
        r_req_cnt  <= r_req_cnt + CNT_ONE;
      end

      if (w_ack_take) begin
        r_rsp_vld  <= 1'b1;
        r_rsp_data <= btod_ack_data;
        r_ack_cnt  <= r_ack_cnt + CNT_ONE;
      end else if (w_rsp_drain) begin
        r_rsp_vld <= 1'b0;
      end

      // Saturates so the flag cannot re-fire after a clear while still waiting.
      if (w_issue) begin
        r_wait_cnt <= '0;
      end else if (w_in_wait && !btod_ack && (r_wait_cnt != WCNT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + WCNT_ONE;
      end

      if (w_to_set) begin
        r_err_timeout <= 1'b1;
      end else if (err_clr) begin
        r_err_timeout <= 1'b0;
      end
    end
  end

  assign btod_req_data = r_req_data;
  assign rsp_vld       = r_rsp_vld;
  assign rsp_data      = r_rsp_data;
  assign started       = r_started;
  assign err_timeout   = r_err_timeout;
  assign req_cnt       = r_req_cnt;
  assign ack_cnt       = r_ack_cnt;

endmodule

// File: tb/tb_btod_req_issuer.sv
// Directed bench for btod_req_issuer with a queue-based reference model checked every cycle.
module tb_btod_req_issuer;

  localparam int TO    = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [31:0] cmd_data;
  logic        btod_req;
  logic [31:0] btod_req_data;
  logic        btod_ack;
  logic [31:0] btod_ack_data;
  logic        start_notify;
  logic        start_ack;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        started;
  logic        err_timeout;
  logic        err_clr;
  logic [15:0] req_cnt;
  logic [15:0] ack_cnt;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  btod_req_issuer #(
    .REQ_W       (32),
    .ACK_W       (32),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_vld       (cmd_vld),
    .cmd_rdy       (cmd_rdy),
    .cmd_data      (cmd_data),
    .btod_req      (btod_req),
    .btod_req_data (btod_req_data),
    .btod_ack      (btod_ack),
    .btod_ack_data (btod_ack_data),
    .start_notify  (start_notify),
    .start_ack     (start_ack),
    .rsp_vld       (rsp_vld),
    .rsp_rdy       (rsp_rdy),
    .rsp_data      (rsp_data),
    .started       (started),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr),
    .req_cnt       (req_cnt),
    .ack_cnt       (ack_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, one outstanding request, cycle count of the wait.
  logic [31:0] q[$];
  bit          m_alive, m_notify, m_started, m_busy, m_rsp_vld, m_err;
  logic [31:0] m_req_data, m_rsp_data;
  logic [15:0] m_req_cnt, m_ack_cnt;
  int          m_wait;
  bit          mv_push, mv_issue, mv_take, mv_set;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_alive = 0; m_notify = 0; m_started = 0; m_busy = 0; m_rsp_vld = 0; m_err = 0;
      m_req_data = '0; m_rsp_data = '0; m_req_cnt = '0; m_ack_cnt = '0; m_wait = 0;
    end else begin
      mv_push  = cmd_vld && m_alive && (q.size() < DEPTH);
      mv_issue = m_started && !m_busy && (q.size() != 0) && (!m_rsp_vld || rsp_rdy);
      mv_take  = m_busy && btod_ack;
      mv_set   = m_busy && !btod_ack && (m_wait == TO - 2);
      if (m_rsp_vld && rsp_rdy) m_rsp_vld = 0;
      if (mv_take) begin
        m_busy = 0; m_rsp_vld = 1; m_rsp_data = btod_ack_data; m_ack_cnt = m_ack_cnt + 16'd1;
      end else if (m_busy) begin
        m_wait++;
      end
      if (mv_issue) begin
        m_req_data = q.pop_front(); m_busy = 1; m_wait = 0; m_req_cnt = m_req_cnt + 16'd1;
      end
      if (mv_push) q.push_back(cmd_data);
      if (mv_set) m_err = 1;
      else if (err_clr) m_err = 0;
      if (m_notify && start_ack) begin m_notify = 0; m_started = 1; end
      if (!m_alive) begin m_alive = 1; m_notify = 1; end
    end
  end

  logic [31:0] req_log[$];
  logic [31:0] rsp_log[$];
  logic        prev_req = 1'b0;
  logic        prev_rsp = 1'b0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chkb("m_cmd_rdy", cmd_rdy, m_alive && (q.size() < DEPTH));
      chkb("m_btod_req", btod_req, m_busy);
      chkb("m_start_notify", start_notify, m_notify);
      chkb("m_started", started, m_started);
      chkb("m_rsp_vld", rsp_vld, m_rsp_vld);
      chkb("m_err_timeout", err_timeout, m_err);
      chkw("m_req_cnt", {16'h0, req_cnt}, {16'h0, m_req_cnt});
      chkw("m_ack_cnt", {16'h0, ack_cnt}, {16'h0, m_ack_cnt});
      if (m_busy) chkw("m_req_data", btod_req_data, m_req_data);
      if (m_rsp_vld) chkw("m_rsp_data", rsp_data, m_rsp_data);
      if (btod_req && !prev_req) req_log.push_back(btod_req_data);
      if (rsp_vld && !prev_rsp) rsp_log.push_back(rsp_data);
      prev_req = btod_req;
      prev_rsp = rsp_vld;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!btod_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chkb("req_seen", btod_req, 1'b1);
  endtask

  // Acks so that btod_ack is sampled dly edges after the req edge.
  task automatic ack_one(input logic [31:0] d, input int dly);
    wait_req();
    repeat (dly - 1) @(negedge clk);
    btod_ack      = 1'b1;
    btod_ack_data = d;
    @(negedge clk);
    btod_ack = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] d);
    cmd_vld  = 1'b1;
    cmd_data = d;
    @(negedge clk);
    cmd_vld  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_data = '0; btod_ack = 1'b0; btod_ack_data = '0;
    start_ack = 1'b0; rsp_rdy = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chkb("rst_cmd_rdy", cmd_rdy, 1'b0);
    chkb("rst_notify", start_notify, 1'b0);
    chkw("rst_req_cnt", {16'h0, req_cnt}, 32'd0);

    // Startup handshake with two commands queued meanwhile
    rst_n   = 1'b1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    chkb("notify_cycle2", start_notify, 1'b1);
    chkb("rdy_after_start", cmd_rdy, 1'b1);
    push_one(32'h1111_0001);
    push_one(32'h1111_0002);
    repeat (6) begin
      @(negedge clk);
      chkb("req_before_start", btod_req, 1'b0);
      chkb("notify_held", start_notify, 1'b1);
    end
    start_ack = 1'b1;
    @(negedge clk);
    start_ack = 1'b0;
    chkb("started_set", started, 1'b1);
    chkb("notify_dropped", start_notify, 1'b0);
    chkb("req_not_yet", btod_req, 1'b0);
    ack_one(32'hBEEF_0001, 1);
    ack_one(32'hBEEF_0002, 1);
    rsp_rdy = 1'b0;

    // Response held: fill FIFO, no new request until the response drains
    chkb("rsp_held", rsp_vld, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cmd_vld  = 1'b1;
      cmd_data = 32'hA5A5_0000 + 32'(i);
      @(negedge clk);
    end
    cmd_vld = 1'b0;
    chkb("full_rdy_low", cmd_rdy, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chkb("hold_no_req", btod_req, 1'b0);
      chkw("hold_rsp_data", rsp_data, 32'hBEEF_0002);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    chkb("req_on_drain", btod_req, 1'b1);
    chkw("req_data_first", btod_req_data, 32'hA5A5_0001);
    chkb("rsp_drained", rsp_vld, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      ack_one(32'hC0DE_0000 + 32'(i), 3);
    end
    @(negedge clk);
    chkw("req_cnt_6", {16'h0, req_cnt}, 32'd6);
    chkw("ack_cnt_6", {16'h0, ack_cnt}, 32'd6);
    chkw("n_reqs", 32'(req_log.size()), 32'd6);
    chkw("n_rsps", 32'(rsp_log.size()), 32'd6);
    for (int i = 0; i < 4; i++) begin
      chkw("req_order", req_log[i+2], 32'hA5A5_0001 + 32'(i));
      chkw("rsp_order", rsp_log[i+2], 32'hC0DE_0001 + 32'(i));
    end

    // Timeout: flag at cycle 16 of the wait, request still held
    push_one(32'h7777_0001);
    wait_req();
    repeat (14) @(negedge clk);
    chkb("err_cycle15", err_timeout, 1'b0);
    @(negedge clk);
    chkb("err_cycle16", err_timeout, 1'b1);
    chkb("req_still_held", btod_req, 1'b1);
    chkw("req_data_held", btod_req_data, 32'h7777_0001);
    ack_one(32'hD00D_0001, 1);
    chkb("err_sticky", err_timeout, 1'b1);
    chkw("rsp_after_to", rsp_data, 32'hD00D_0001);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chkb("err_cleared", err_timeout, 1'b0);

    // Clear in the same cycle as set: set wins
    push_one(32'h7777_0002);
    wait_req();
    repeat (14) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chkb("err_set_wins", err_timeout, 1'b1);
    ack_one(32'hD00D_0002, 1);
    @(negedge clk);

    // Stray acks while idle
    btod_ack = 1'b1; btod_ack_data = 32'hBAD0_BAD0; start_ack = 1'b1;
    @(negedge clk);
    btod_ack = 1'b0; start_ack = 1'b0;
    chkw("stray_ack_cnt", {16'h0, ack_cnt}, 32'd8);
    chkb("stray_rsp_vld", rsp_vld, 1'b0);
    chkw("stray_rsp_data", rsp_data, 32'hD00D_0002);
    chkb("stray_req", btod_req, 1'b0);
    chkb("stray_notify", start_notify, 1'b0);

    // Reset during a wait
    push_one(32'h5555_0001);
    push_one(32'h5555_0002);
    wait_req();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chkb("rst_req", btod_req, 1'b0);
    chkb("rst_started", started, 1'b0);
    chkb("rst_rdy", cmd_rdy, 1'b0);
    chkb("rst_err", err_timeout, 1'b0);
    chkw("rst_req_cnt2", {16'h0, req_cnt}, 32'd0);
    chkw("rst_ack_cnt2", {16'h0, ack_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("renotify", start_notify, 1'b1);
    chkb("fifo_empty_rdy", cmd_rdy, 1'b1);
    start_ack = 1'b1;
    @(negedge clk);
    start_ack = 1'b0;
    chkb("restarted", started, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chkb("fifo_flushed", btod_req, 1'b0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
